// File: rtl/cam_pkg.sv
// Shared constants and enums for the CAM requester slice.
package cam_pkg;
    localparam int NB_MEM = 16;
    localparam int ADDR_W = 5;
    localparam int KEY_W  = 8;

    // The CAM memory resets to zero, so key 0 would always match.
    localparam logic [KEY_W-1:0] RESERVED_KEY = 8'h00;

    typedef enum logic {
        OP_LOOKUP = 1'b0,
        OP_INSERT = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        CHECK,
        WRITE,
        RESP
    } state_e;
endpackage

// File: rtl/cam_slot_alloc.sv
// Monotonic CAM slot allocator: free pointer counts 0..NB_MEM, slots are only
// reclaimed by reset.
module cam_slot_alloc
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] free_ptr,
    output logic              full
);
    logic [ADDR_W-1:0] free_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_ptr_reg <= '0;
        end else if (inc && !full) begin
            free_ptr_reg <= free_ptr_reg + 1'b1;
        end
    end

    assign free_ptr = free_ptr_reg;
    assign full     = (free_ptr_reg == ADDR_W'(NB_MEM));
endmodule

// File: rtl/cam_client.sv
// Requester side of the 16-entry CAM: sequences search/write strobes, allocates
// slots and returns one response per request. Optional CAM_CLIENT_STATS_EN adds hit/miss counters.
module cam_client
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [KEY_W-1:0]  req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_idx,
    output logic              rsp_err,
    output logic              cam_enable,
    output logic              cam_write,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [KEY_W-1:0]  cam_data,
    input  logic [ADDR_W-1:0] cam_out,
    input  logic              cam_found,
    output logic              full
`ifdef CAM_CLIENT_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);
    state_e            state_reg, state_next;
    op_e               op_reg, op_next;
    logic [KEY_W-1:0]  key_reg, key_next;
    logic              rsp_hit_reg, rsp_hit_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [ADDR_W-1:0] rsp_idx_reg, rsp_idx_next;
    logic              cam_enable_reg, cam_enable_next;
    logic              cam_write_reg, cam_write_next;
    logic [ADDR_W-1:0] cam_addr_reg, cam_addr_next;
    logic [KEY_W-1:0]  cam_data_reg, cam_data_next;
    logic [ADDR_W-1:0] free_ptr;
    logic              alloc_inc;

    cam_slot_alloc u_alloc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (alloc_inc),
        .free_ptr (free_ptr),
        .full     (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            op_reg         <= OP_LOOKUP;
            key_reg        <= '0;
            rsp_hit_reg    <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_idx_reg    <= '0;
            cam_enable_reg <= 1'b0;
            cam_write_reg  <= 1'b0;
            cam_addr_reg   <= '0;
            cam_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            key_reg        <= key_next;
            rsp_hit_reg    <= rsp_hit_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_idx_reg    <= rsp_idx_next;
            cam_enable_reg <= cam_enable_next;
            cam_write_reg  <= cam_write_next;
            cam_addr_reg   <= cam_addr_next;
            cam_data_reg   <= cam_data_next;
        end
    end

    // CAM strobes are registered one state ahead so they are high exactly in SEARCH/WRITE.
    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        key_next        = key_reg;
        rsp_hit_next    = rsp_hit_reg;
        rsp_err_next    = rsp_err_reg;
        rsp_idx_next    = rsp_idx_reg;
        cam_enable_next = 1'b0;
        cam_write_next  = 1'b0;
        cam_addr_next   = '0;
        cam_data_next   = '0;
        alloc_inc       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next      = op_e'(req_op);
                    key_next     = req_key;
                    rsp_hit_next = 1'b0;
                    rsp_idx_next = '0;
                    rsp_err_next = 1'b0;
                    if (req_key == RESERVED_KEY) begin
                        rsp_err_next = 1'b1;
                        state_next   = RESP;
                    end else begin
                        cam_enable_next = 1'b1;
                        cam_data_next   = req_key;
                        state_next      = SEARCH;
                    end
                end
            end
            SEARCH: state_next = CHECK;
            CHECK: begin
                if (cam_found) begin
                    rsp_hit_next = 1'b1;
                    rsp_idx_next = cam_out;
                    state_next   = RESP;
                end else if (op_reg == OP_LOOKUP) begin
                    state_next = RESP;
                end else if (!full) begin
                    cam_write_next = 1'b1;
                    cam_addr_next  = free_ptr;
                    cam_data_next  = key_reg;
                    state_next     = WRITE;
                end else begin
                    rsp_err_next = 1'b1;
                    state_next   = RESP;
                end
            end
            WRITE: begin
                rsp_idx_next = free_ptr;
                alloc_inc    = 1'b1;
                state_next   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state_reg == IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_hit    = rsp_hit_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_idx    = rsp_idx_reg;
    assign cam_enable = cam_enable_reg;
    assign cam_write  = cam_write_reg;
    assign cam_addr   = cam_addr_reg;
    assign cam_data   = cam_data_reg;

`ifdef CAM_CLIENT_STATS_EN
    logic [15:0] stat_hits_reg, stat_misses_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_reg   <= '0;
            stat_misses_reg <= '0;
        end else if (state_reg == CHECK) begin
            if (cam_found) begin
                if (stat_hits_reg != 16'hFFFF) stat_hits_reg <= stat_hits_reg + 1'b1;
            end else begin
                if (stat_misses_reg != 16'hFFFF) stat_misses_reg <= stat_misses_reg + 1'b1;
            end
        end
    end

    assign stat_hits   = stat_hits_reg;
    assign stat_misses = stat_misses_reg;
`endif
endmodule

// File: tb/tb_cam_client.sv
// Bench for cam_client: behavioural CAM plus a key-table model predicting each response.
module tb_cam_client;
    import cam_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_op = 1'b0;
    logic [KEY_W-1:0]  req_key = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_idx;
    logic              rsp_err;
    logic              cam_enable;
    logic              cam_write;
    logic [ADDR_W-1:0] cam_addr;
    logic [KEY_W-1:0]  cam_data;
    logic [ADDR_W-1:0] cam_out;
    logic              cam_found;
    logic              full;
`ifdef CAM_CLIENT_STATS_EN
    logic [15:0]       stat_hits;
    logic [15:0]       stat_misses;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    cam_client dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_idx    (rsp_idx),
        .rsp_err    (rsp_err),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out),
        .cam_found  (cam_found),
        .full       (full)
`ifdef CAM_CLIENT_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural CAM: registered lowest-index match, memory cleared by reset.
    logic [KEY_W-1:0] cam_mem [NB_MEM];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_MEM; i++) cam_mem[i] <= '0;
            cam_found <= 1'b0;
            cam_out   <= '0;
        end else begin
            if (cam_enable) begin
                cam_found <= 1'b0;
                cam_out   <= '0;
                for (int i = NB_MEM - 1; i >= 0; i--) begin
                    if (cam_mem[i] == cam_data) begin
                        cam_found <= 1'b1;
                        cam_out   <= ADDR_W'(i);
                    end
                end
            end
            if (cam_write) cam_mem[cam_addr[3:0]] <= cam_data;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Reference model: ordered table of stored keys; slot index is table position.
    logic [KEY_W-1:0] tbl[$];
    int  s_hits = 0, s_misses = 0;
    bit  exp_active = 0;
    bit  exp_hit, exp_err, exp_wr;
    int  exp_idx, exp_lat;

    function automatic void predict(input bit op, input logic [KEY_W-1:0] key);
        int pos = -1;
        exp_hit = 0; exp_err = 0; exp_wr = 0; exp_idx = 0; exp_lat = 3;
        if (key == 8'h00) begin
            exp_err = 1; exp_lat = 1;
            return;
        end
        for (int i = 0; i < tbl.size(); i++) if (pos < 0 && tbl[i] == key) pos = i;
        if (pos >= 0) begin
            exp_hit = 1; exp_idx = pos; s_hits++;
        end else begin
            s_misses++;
            if (op) begin
                if (tbl.size() == NB_MEM) exp_err = 1;
                else begin
                    exp_idx = tbl.size(); exp_wr = 1; exp_lat = 4;
                    tbl.push_back(key);
                end
            end
        end
    endfunction

    // Strobe monitor: cumulative counts and last strobe payloads.
    int en_total = 0, wr_total = 0;
    logic [ADDR_W-1:0] last_wa;
    logic [KEY_W-1:0]  last_wd, last_ed;
    always @(negedge clk) begin
        if (cam_enable) begin en_total++; last_ed = cam_data; end
        if (cam_write) begin wr_total++; last_wa = cam_addr; last_wd = cam_data; end
    end

    // Per-cycle compare against the model whenever a response is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cam_enable && cam_write) chk("strobe_excl", 1, 0);
            if (rsp_valid) begin
                chk("rsp_expected", int'(exp_active), 1);
                chk("rsp_hit", int'(rsp_hit), int'(exp_hit));
                chk("rsp_idx", int'(rsp_idx), exp_idx);
                chk("rsp_err", int'(rsp_err), int'(exp_err));
                chk("req_ready_busy", int'(req_ready), 0);
            end
        end
    end

    task automatic do_req(input bit op, input logic [KEY_W-1:0] key, input int hold,
                          output logic h, output logic [ADDR_W-1:0] idx, output logic e);
        int e0, w0, lat;
        predict(op, key);
        e0 = en_total; w0 = wr_total;
        @(negedge clk);
        chk("req_ready_idle", int'(req_ready), 1);
        req_valid = 1'b1; req_op = op; req_key = key; exp_active = 1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        h = rsp_hit; idx = rsp_idx; e = rsp_err;
        repeat (hold) @(negedge clk);
        chk("enable_pulses", en_total - e0, (key == 8'h00) ? 0 : 1);
        chk("write_pulses", wr_total - w0, int'(exp_wr));
        if (key != 8'h00) chk("search_key", int'(last_ed), int'(key));
        if (exp_wr) begin
            chk("write_addr", int'(last_wa), exp_idx);
            chk("write_data", int'(last_wd), int'(key));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_active = 0;
        chk("rsp_consumed", int'(rsp_valid), 0);
        chk("full_model", int'(full), int'(tbl.size() == NB_MEM));
        $display("req op=%0d key=%02h -> hit=%0d idx=%0d err=%0d lat=%0d", op, key, h, idx, e, lat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tbl.delete(); s_hits = 0; s_misses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h, e;
        logic [ADDR_W-1:0] idx;
        int n;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_fields", int'({rsp_hit, rsp_err, rsp_idx}), 0);
        chk("reset_cam", int'({cam_enable, cam_write, cam_addr, cam_data}), 0);
        chk("reset_full", int'(full), 0);
        rst_n = 1'b1;

        // rsp_ready while idle has no effect
        @(negedge clk);
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rsp_ready", int'({rsp_valid, req_ready}), 1);
        end
        rsp_ready = 1'b0;

        do_req(1'b1, 8'hA5, 0, h, idx, e);
        chk("ins_a5_lit", int'({h, idx, e}), 0);
        do_req(1'b0, 8'hA5, 0, h, idx, e);
        chk("lkp_a5_hit_lit", int'(h), 1);
        chk("lkp_a5_idx_lit", int'(idx), 0);
        do_req(1'b0, 8'h3C, 0, h, idx, e);
        chk("lkp_3c_lit", int'({h, e}), 0);
        do_req(1'b1, 8'hA5, 0, h, idx, e);
        chk("reins_a5_lit", int'({h, idx}), 32);
        do_req(1'b1, 8'h5A, 0, h, idx, e);
        chk("ptr_after_dup_lit", int'(idx), 1);

        do_reset();
        for (int k = 1; k <= 16; k++) begin
            do_req(1'b1, 8'(k), 0, h, idx, e);
            chk("fill_idx_lit", int'(idx), k - 1);
        end
        chk("full_lit", int'(full), 1);
        do_req(1'b1, 8'h77, 0, h, idx, e);
        chk("ins_full_err_lit", int'({h, e}), 1);
        do_req(1'b0, 8'h10, 0, h, idx, e);
        chk("lkp_10_lit", int'(idx), 15);

        do_req(1'b0, 8'h00, 5, h, idx, e);
        chk("reserved_err_lit", int'({h, idx, e}), 1);

        // Reset asserted during WRITE drops the request
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b1; req_key = 8'h42;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!cam_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("write_cycle", n, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_strobes", int'({cam_enable, cam_write}), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        tbl.delete(); s_hits = 0; s_misses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("no_rsp_after_rst", int'(rsp_valid), 0);
        end
        do_req(1'b1, 8'h42, 0, h, idx, e);
        chk("post_rst_idx_lit", int'({h, idx, e}), 0);
        do_req(1'b0, 8'h42, 0, h, idx, e);

`ifdef CAM_CLIENT_STATS_EN
        chk("stat_hits", int'(stat_hits), s_hits);
        chk("stat_misses", int'(stat_misses), s_misses);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
